// File: rtl/xy_router_rr_pkg.sv
// rtl/xy_router_rr_pkg.sv - shared port indices, types and round-robin pick helper
package xy_router_rr_pkg;

    localparam int PORT_N     = 5;
    localparam int PORT_IDX_W = 3;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    localparam port_idx_t P_LEFT  = 3'd0;
    localparam port_idx_t P_TOP   = 3'd1;
    localparam port_idx_t P_RIGHT = 3'd2;
    localparam port_idx_t P_BOT   = 3'd3;
    localparam port_idx_t P_RES   = 3'd4;

    // First requester strictly after ptr in cyclic order 0..4; returns ptr when nothing requests.
    function automatic port_idx_t rr_pick(input logic [PORT_N-1:0] req, input port_idx_t ptr);
        port_idx_t pick;
        port_idx_t idx;
        pick = ptr;
        for (int k = PORT_N; k >= 1; k--) begin
            idx = PORT_IDX_W'((int'(ptr) + k) % PORT_N);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/xy_router_rr_if.sv
// rtl/xy_router_rr_if.sv - five-port packet bus between router and its neighbours
interface xy_router_rr_if #(
    parameter int PACKET_W = 16
);
    logic [4:0]            pckt_vld_i;
    logic [5*PACKET_W-1:0] pckt_i;
    logic [4:0]            pckt_rdy_o;
    logic [4:0]            pckt_vld_o;
    logic [5*PACKET_W-1:0] pckt_o;
    logic [4:0]            pckt_rdy_i;
    logic                  busy_o;
    logic                  drop_o;

    modport slave (
        input  pckt_vld_i, pckt_i, pckt_rdy_i,
        output pckt_rdy_o, pckt_vld_o, pckt_o, busy_o, drop_o
    );

    modport master (
        output pckt_vld_i, pckt_i, pckt_rdy_i,
        input  pckt_rdy_o, pckt_vld_o, pckt_o, busy_o, drop_o
    );
endinterface

// File: rtl/xy_router_rr_fifo.sv
// rtl/xy_router_rr_fifo.sv - per-input packet FIFO with wrapping pointers and full flag
module xy_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic             r_full;
    logic [AW-1:0]    w_wr_nxt;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_empty  = (r_wr == r_rd) && !r_full;
    assign w_push   = i_push && !r_full;
    assign w_pop    = i_pop && !w_empty;
    assign w_wr_nxt = r_wr + AW'(1);

    assign o_data  = r_mem[r_rd];
    assign o_empty = w_empty;
    assign o_full  = r_full;

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointer and full-flag update; pointers wrap modulo DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (w_push && !w_pop && (w_wr_nxt == r_rd)) begin
                r_full <= 1'b1;
            end else if (w_pop && !w_push) begin
                r_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/xy_router_rr.sv
// rtl/xy_router_rr.sv - buffered five-port XY mesh router with per-output round-robin
module xy_router_rr #(
    parameter int         X_CORD     = 0,
    parameter int         Y_CORD     = 0,
    parameter int         ADDR_X_W   = 4,
    parameter int         ADDR_Y_W   = 4,
    parameter int         DATA_W     = 8,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [4:0] PORT_EN    = 5'b11111
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    xy_router_rr_if.slave bus
);
    import xy_router_rr_pkg::*;

    localparam int PACKET_W = ADDR_X_W + ADDR_Y_W + DATA_W;
    localparam logic [ADDR_X_W-1:0] C_X = ADDR_X_W'(X_CORD);
    localparam logic [ADDR_Y_W-1:0] C_Y = ADDR_Y_W'(Y_CORD);

    logic [PACKET_W-1:0]                w_head [PORT_N];
    logic [PORT_N-1:0]                  w_empty;
    logic [PORT_N-1:0]                  w_full;
    logic [PORT_N-1:0]                  w_push;
    logic [PORT_N-1:0]                  w_pop;
    logic [PORT_N-1:0]                  w_drop;
    port_idx_t                          w_route [PORT_N];
    logic [PORT_N-1:0][PORT_N-1:0]      w_req;
    logic [PORT_N-1:0]                  w_free;
    logic [PORT_N-1:0]                  w_gnt_vld;
    port_idx_t                          w_gnt_idx [PORT_N];

    logic [PACKET_W-1:0]                r_out [PORT_N];
    logic [PORT_N-1:0]                  r_vld;
    port_idx_t                          r_ptr [PORT_N];

    genvar g;
    generate
        for (g = 0; g < PORT_N; g++) begin : g_port
            assign bus.pckt_rdy_o[g] = PORT_EN[g] && !w_full[g];
            assign w_push[g]         = PORT_EN[g] && !w_full[g] && bus.pckt_vld_i[g];
            assign bus.pckt_o[g*PACKET_W +: PACKET_W] = r_out[g];

            xy_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (PACKET_W)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .i_push  (w_push[g]),
                .i_data  (bus.pckt_i[g*PACKET_W +: PACKET_W]),
                .i_pop   (w_pop[g]),
                .o_data  (w_head[g]),
                .o_empty (w_empty[g]),
                .o_full  (w_full[g])
            );
        end
    endgenerate

    // XY routing of each FIFO head, then drop detection and the request matrix.
    always_comb begin
        w_req  = '0;
        w_drop = '0;
        for (int p = 0; p < PORT_N; p++) begin
            logic [ADDR_X_W-1:0] v_x;
            logic [ADDR_Y_W-1:0] v_y;
            v_x = w_head[p][PACKET_W-1 -: ADDR_X_W];
            v_y = w_head[p][DATA_W +: ADDR_Y_W];
            if (v_x > C_X) begin
                w_route[p] = P_RIGHT;
            end else if (v_x < C_X) begin
                w_route[p] = P_LEFT;
            end else if (v_y > C_Y) begin
                w_route[p] = P_BOT;
            end else if (v_y < C_Y) begin
                w_route[p] = P_TOP;
            end else begin
                w_route[p] = P_RES;
            end
            if (!w_empty[p]) begin
                if (PORT_EN[w_route[p]]) begin
                    w_req[w_route[p]][p] = 1'b1;
                end else begin
                    w_drop[p] = 1'b1;
                end
            end
        end
    end

    // Per-output grant: a free output register takes the next requester after its pointer.
    always_comb begin
        w_pop = w_drop;
        for (int o = 0; o < PORT_N; o++) begin
            w_free[o]    = !r_vld[o] || bus.pckt_rdy_i[o];
            w_gnt_vld[o] = w_free[o] && (|w_req[o]);
            w_gnt_idx[o] = rr_pick(w_req[o], r_ptr[o]);
            if (w_gnt_vld[o]) begin
                w_pop[w_gnt_idx[o]] = 1'b1;
            end
        end
    end

    // Output registers and arbiter pointers; a drained register is refilled in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
            for (int o = 0; o < PORT_N; o++) begin
                r_out[o] <= '0;
                r_ptr[o] <= P_RES;
            end
        end else begin
            for (int o = 0; o < PORT_N; o++) begin
                if (w_gnt_vld[o]) begin
                    r_out[o] <= w_head[w_gnt_idx[o]];
                    r_vld[o] <= 1'b1;
                    r_ptr[o] <= w_gnt_idx[o];
                end else if (w_free[o]) begin
                    r_vld[o] <= 1'b0;
                end
            end
        end
    end

    assign bus.pckt_vld_o = r_vld;
    assign bus.busy_o     = (~&w_empty) || (|r_vld);
    assign bus.drop_o     = |w_drop;

endmodule
